// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the write-back path.
// Holds the write-back select encodings used by mem_wb_pipe and by the
// hazard unit, which reuses wb_sel_mux. The slot struct depends on module
// widths, so each including module declares it locally from its own
// DATA_W / RADDR_W parameters.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

endpackage

// File: rtl/wb_sel_mux.sv
// wb_sel_mux: combinational write-back select with zero-register gating.
// Ports:
//   wb_sel      - 0=ALU, 1=MEM, 2=LINK, 3=reserved (treated as ALU)
//   mem_rdata   - load data
//   alu_result  - ALU result
//   next_pc     - link address
//   reg_wen     - raw register write enable
//   reg_waddr   - destination register
//   wb_data     - selected write-back word
//   wen         - write enable with the zero-register suppression applied
module wb_sel_mux
  import wb_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int RADDR_W     = 4,
  parameter int ZERO_REG_RO = 1
) (
  input  logic [1:0]         wb_sel,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [DATA_W-1:0]  next_pc,
  input  logic               reg_wen,
  input  logic [RADDR_W-1:0] reg_waddr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               wen
);

  always_comb begin
    case (wb_sel)
      WB_SEL_MEM:  wb_data = mem_rdata;
      WB_SEL_LINK: wb_data = next_pc;
      // Reserved encoding falls back to the ALU result.
      default:     wb_data = alu_result;
    endcase
  end

  // Register 0 is hardwired when ZERO_REG_RO is set, so its writes are dropped.
  assign wen = reg_wen & ~((ZERO_REG_RO != 0) && (reg_waddr == '0));

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB pipeline stage with a 2-entry skid buffer.
// The write-back word is resolved at enqueue, so slots hold only
// {wen, waddr, data} and the WB side sees registered values directly.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush           - discard all held entries
//   in_*            - MEM-side entry with valid/ready handshake
//   out_*           - head entry with valid/ready handshake
//   fwd_*           - forwarding tap for the hazard unit
module mem_wb_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int RADDR_W     = 4,
  parameter int ZERO_REG_RO = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_reg_wen,
  input  logic [RADDR_W-1:0] in_reg_waddr,
  input  logic [DATA_W-1:0]  in_mem_rdata,
  input  logic [DATA_W-1:0]  in_alu_result,
  input  logic [DATA_W-1:0]  in_next_pc,
  input  logic [1:0]         in_wb_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_reg_wen,
  output logic [RADDR_W-1:0] out_reg_waddr,
  output logic [DATA_W-1:0]  out_wb_data,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_waddr,
  output logic [DATA_W-1:0]  fwd_data
);

  typedef struct packed {
    logic               wen;
    logic [RADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  data;
  } slot_t;

  slot_t head_q, head_d;
  slot_t skid_q, skid_d;
  logic  head_valid_q, head_valid_d;
  logic  skid_valid_q, skid_valid_d;
  slot_t new_slot;
  logic  accept;
  logic  pop;

  wb_sel_mux #(
    .DATA_W      (DATA_W),
    .RADDR_W     (RADDR_W),
    .ZERO_REG_RO (ZERO_REG_RO)
  ) u_sel (
    .wb_sel     (in_wb_sel),
    .mem_rdata  (in_mem_rdata),
    .alu_result (in_alu_result),
    .next_pc    (in_next_pc),
    .reg_wen    (in_reg_wen),
    .reg_waddr  (in_reg_waddr),
    .wb_data    (new_slot.data),
    .wen        (new_slot.wen)
  );

  assign new_slot.waddr = in_reg_waddr;

  // Ready depends only on registered state, so there is no path from out_ready.
  assign in_ready = ~skid_valid_q & ~rst;
  assign accept   = in_valid & in_ready;
  assign pop      = head_valid_q & out_ready;

  // Next-state: occupancy is encoded by the two valid bits; SKID is always
  // the younger entry, so it only ever moves forward into HEAD.
  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    if (rst) begin
      head_d       = '0;
      skid_d       = '0;
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (flush) begin
      // Data may go stale; only the valids matter once cleared.
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q) begin
      if (accept) begin
        head_d       = new_slot;
        head_valid_d = 1'b1;
      end
    end else if (!skid_valid_q) begin
      if (accept && pop) begin
        head_d = new_slot;
      end else if (accept) begin
        skid_d       = new_slot;
        skid_valid_d = 1'b1;
      end else if (pop) begin
        head_valid_d = 1'b0;
      end
    end else if (pop) begin
      head_d       = skid_q;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    head_q       <= head_d;
    skid_q       <= skid_d;
    head_valid_q <= head_valid_d;
    skid_valid_q <= skid_valid_d;
  end

  assign out_valid     = head_valid_q;
  assign out_reg_wen   = head_valid_q & head_q.wen;
  assign out_reg_waddr = head_q.waddr;
  assign out_wb_data   = head_q.data;
  assign fwd_valid     = out_reg_wen;
  assign fwd_waddr     = head_q.waddr;
  assign fwd_data      = head_q.data;

endmodule
